// File: rtl/mdu_ctrl_pkg.sv
// Shared MDU constants: op encodings, FSM state codes, default latencies.
// Imported by the control decoder, mdu_calc and mdu_ctrl.
package mdu_ctrl_pkg;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    function automatic logic is_div(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_arith(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || is_div(op);
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational MDU arithmetic on latched operands.
// Ports: a, b operands; op selects mult/div flavour; hi/lo result; div0 flags b==0.
module mdu_calc
    import mdu_ctrl_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  op,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div0
);

    logic        sgn;
    logic [31:0] ma;
    logic [31:0] mb;
    logic [31:0] mb_safe;
    logic [31:0] q;
    logic [31:0] r;
    logic [63:0] prod;

    // Signed ops work on magnitudes, then fix signs. This also makes
    // 0x80000000 / -1 come out as 0x80000000 rem 0 without a special case.
    always_comb begin
        sgn     = (op == OP_MULT) || (op == OP_DIV);
        ma      = (sgn && a[31]) ? -a : a;
        mb      = (sgn && b[31]) ? -b : b;
        div0    = (b == 32'd0);
        mb_safe = div0 ? 32'd1 : mb;
        prod    = {32'd0, ma} * {32'd0, mb};
        q       = ma / mb_safe;
        r       = ma % mb_safe;
        if (sgn && (a[31] ^ b[31])) begin
            prod = -prod;
            q    = -q;
        end
        if (sgn && a[31]) begin
            r = -r;
        end
        if (is_div(op)) begin
            hi = r;
            lo = q;
        end else begin
            hi = prod[63:32];
            lo = prod[31:0];
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle MDU controller: FSM, latency counter, HI/LO and pipeline stall.
// Ports: clk, reset (async low); E-stage op/operands; D_is_md; start/busy/stall; HI/LO; E_MD_out.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        E_valid,
    input  logic [3:0]  E_MD_op,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        D_is_md,
    output logic        start,
    output logic        busy,
    output logic        stall,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] E_MD_out
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [31:0]   a_q;
    logic [31:0]   b_q;
    logic [3:0]    op_q;
    logic [31:0]   calc_hi;
    logic [31:0]   calc_lo;
    logic          calc_div0;

    mdu_calc u_calc (
        .a    (a_q),
        .b    (b_q),
        .op   (op_q),
        .hi   (calc_hi),
        .lo   (calc_lo),
        .div0 (calc_div0)
    );

    assign busy  = (state != S_IDLE);
    assign start = E_valid & is_arith(E_MD_op) & (state == S_IDLE);
    assign stall = D_is_md & (start | busy);

    always_comb begin
        E_MD_out = 32'd0;
        if (E_MD_op == OP_MFHI) begin
            E_MD_out = HI;
        end else if (E_MD_op == OP_MFLO) begin
            E_MD_out = LO;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            HI    <= 32'd0;
            LO    <= 32'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            op_q  <= OP_NONE;
        end else if (start) begin
            a_q  <= E_A;
            b_q  <= E_B;
            op_q <= E_MD_op;
            if (is_div(E_MD_op)) begin
                state <= S_DIV;
                cnt   <= CW'(DIV_CYCLES);
            end else begin
                state <= S_MUL;
                cnt   <= CW'(MULT_CYCLES);
            end
        end else if (busy) begin
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
                state <= S_IDLE;
                // A zero divisor burns the full latency but leaves HI/LO intact.
                if (!((state == S_DIV) && calc_div0)) begin
                    HI <= calc_hi;
                    LO <= calc_lo;
                end
            end
        end else if (E_valid && (E_MD_op == OP_MTHI)) begin
            HI <= E_A;
        end else if (E_valid && (E_MD_op == OP_MTLO)) begin
            LO <= E_A;
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl.
// Drives on negedge, checks #1 later; HI/LO expectations are hand-computed.
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    logic        clk;
    logic        reset;
    logic        E_valid;
    logic [3:0]  E_MD_op;
    logic [31:0] E_A;
    logic [31:0] E_B;
    logic        D_is_md;
    logic        start;
    logic        busy;
    logic        stall;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] E_MD_out;

    int n_chk  = 0;
    int n_fail = 0;

    mdu_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .E_valid  (E_valid),
        .E_MD_op  (E_MD_op),
        .E_A      (E_A),
        .E_B      (E_B),
        .D_is_md  (D_is_md),
        .start    (start),
        .busy     (busy),
        .stall    (stall),
        .HI       (HI),
        .LO       (LO),
        .E_MD_out (E_MD_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arithmetic ops must never reach E while the unit is busy.
    always @(posedge clk) begin
        if (reset && busy && E_valid && is_arith(E_MD_op)) begin
            $error("mult/div issued while busy, op=%0d", E_MD_op);
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_op(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int n,
                         input logic dmd);
        int k;
        @(negedge clk);
        E_valid = 1'b1;
        E_MD_op = op;
        E_A     = a;
        E_B     = b;
        D_is_md = dmd;
        #1;
        check("start", {31'd0, start}, 32'd1);
        check("stall_st", {31'd0, stall}, {31'd0, dmd});
        @(negedge clk);
        E_valid = 1'b0;
        E_MD_op = OP_NONE;
        k = 0;
        while (busy && k < 40) begin
            #1;
            if (dmd) check("stall_busy", {31'd0, stall}, 32'd1);
            k++;
            @(negedge clk);
        end
        #1;
        check("busy_len", 32'(k), 32'(n));
        check("stall_end", {31'd0, stall}, 32'd0);
        D_is_md = 1'b0;
    endtask

    task automatic wr(input logic [3:0] op, input logic [31:0] a,
                      input logic v);
        @(negedge clk);
        E_valid = v;
        E_MD_op = op;
        E_A     = a;
        E_B     = 32'd0;
        @(negedge clk);
        E_valid = 1'b0;
        E_MD_op = OP_NONE;
    endtask

    initial begin
        int k;
        reset   = 1'b0;
        E_valid = 1'b0;
        E_MD_op = OP_NONE;
        E_A     = 32'd0;
        E_B     = 32'd0;
        D_is_md = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);

        // Release on a negedge; the very next edge accepts the MULT.
        reset = 1'b1;
        do_op(OP_MULT, 32'd5, 32'hFFFF_FFFD, 5, 1'b1);
        check("mult_hi", HI, 32'hFFFF_FFFF);
        check("mult_lo", LO, 32'hFFFF_FFF1);
        E_MD_op = OP_MFLO;
        E_valid = 1'b1;
        #1;
        check("mflo", E_MD_out, 32'hFFFF_FFF1);
        E_MD_op = OP_MFHI;
        #1;
        check("mfhi", E_MD_out, 32'hFFFF_FFFF);
        E_MD_op = OP_NONE;
        #1;
        check("md_none", E_MD_out, 32'd0);
        E_valid = 1'b0;

        do_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 5, 1'b0);
        check("multu_hi", HI, 32'd1);
        check("multu_lo", LO, 32'hFFFF_FFFE);

        do_op(OP_DIVU, 32'd7, 32'd2, 10, 1'b0);
        check("divu_hi", HI, 32'd1);
        check("divu_lo", LO, 32'd3);

        do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 10, 1'b0);
        check("div_hi", HI, 32'hFFFF_FFFF);
        check("div_lo", LO, 32'hFFFF_FFFD);

        do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b0);
        check("divov_hi", HI, 32'd0);
        check("divov_lo", LO, 32'h8000_0000);

        wr(OP_MTHI, 32'h1234, 1'b1);
        wr(OP_MTLO, 32'h5678, 1'b1);
        check("mthi", HI, 32'h1234);
        check("mtlo", LO, 32'h5678);

        do_op(OP_DIV, 32'd99, 32'd0, 10, 1'b0);
        check("div0_hi", HI, 32'h1234);
        check("div0_lo", LO, 32'h5678);

        // E_valid low: no start, no HI write.
        wr(OP_MTHI, 32'hBEEF, 1'b0);
        check("nv_mthi", HI, 32'h1234);
        @(negedge clk);
        E_MD_op = OP_MULT;
        E_A     = 32'd3;
        E_B     = 32'd3;
        #1;
        check("nv_start", {31'd0, start}, 32'd0);
        @(negedge clk);
        E_MD_op = OP_NONE;
        check("nv_busy", {31'd0, busy}, 32'd0);

        // MTHI forced into E during a zero-divide.
        @(negedge clk);
        E_valid = 1'b1;
        E_MD_op = OP_DIVU;
        E_A     = 32'd9;
        E_B     = 32'd0;
        @(negedge clk);
        E_MD_op = OP_MTHI;
        E_A     = 32'hDEAD;
        #1;
        check("bz_start", {31'd0, start}, 32'd0);
        @(negedge clk);
        E_valid = 1'b0;
        E_MD_op = OP_NONE;
        check("bz_hi_mid", HI, 32'h1234);
        k = 0;
        while (busy && k < 40) begin
            k++;
            @(negedge clk);
        end
        check("bz_len", 32'(k), 32'd9);
        check("bz_hi", HI, 32'h1234);
        check("bz_lo", LO, 32'h5678);

        // Reset at busy cycle 4 of a DIVU.
        @(negedge clk);
        E_valid = 1'b1;
        E_MD_op = OP_DIVU;
        E_A     = 32'd7;
        E_B     = 32'd2;
        @(negedge clk);
        E_valid = 1'b0;
        E_MD_op = OP_NONE;
        repeat (3) @(negedge clk);
        check("r_busy_pre", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        check("r_busy", {31'd0, busy}, 32'd0);
        check("r_hi", HI, 32'd0);
        check("r_lo", LO, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        check("r_busy_post", {31'd0, busy}, 32'd0);
        check("r_hi_post", HI, 32'd0);
        check("r_lo_post", LO, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5: busy cycles for mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10: busy cycles for div/divu.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port E_valid  input  1  E-stage instruction is live (not a bubble or flushed).
REQ-006 SHALL have port E_MD_op  input  4  E-stage MDU op: NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO.
REQ-007 SHALL have port E_A  input  32  forwarded rs value.
REQ-008 SHALL have port E_B  input  32  forwarded rt value.
REQ-009 SHALL have port D_is_md  input  1  D-stage instruction is any MDU op.
REQ-010 SHALL have port start  output  1  combinational; MULT/MULTU/DIV/DIVU accepted this cycle.
REQ-011 SHALL have port busy  output  1  registered; an operation is in flight.
REQ-012 SHALL have port stall  output  1  combinational; freeze F/D and bubble E.
REQ-013 SHALL have port HI  output  32  HI register.
REQ-014 SHALL have port LO  output  32  LO register.
REQ-015 SHALL have port E_MD_out  output  32  HI for MFHI, LO for MFLO, else 0; combinational.

Function
REQ-016 SHALL implement FSM states IDLE, MUL, DIV, plus a down-counter cnt wide enough for DIV_CYCLES.
REQ-017 start SHALL = E_valid & (op in MULT/MULTU/DIV/DIVU) & state==IDLE.
REQ-018 On a start edge: latch E_A, E_B and op; cnt <= N (N per REQ-001/002); state <= MUL or DIV.
REQ-019 In MUL/DIV: cnt decrements each cycle; on the edge where cnt==1, write HI/LO and return to IDLE.
REQ-020 busy SHALL = (state!=IDLE): high for exactly N cycles after the start cycle; new HI/LO are visible in the first cycle busy is low.
REQ-021 stall SHALL = D_is_md & (start | busy).
REQ-022 MULT: {HI,LO} = signed 64-bit product. MULTU: unsigned 64-bit product.
REQ-023 DIV: LO = signed quotient truncated toward zero; HI = remainder, sign of dividend. 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
REQ-024 DIVU: LO = unsigned quotient; HI = unsigned remainder.
REQ-025 Divisor 0: the block stays busy DIV_CYCLES; HI and LO keep their prior values.
REQ-026 MTHI/MTLO with E_valid & state==IDLE SHALL write E_A into HI/LO on that edge; when busy they are ignored.
REQ-027 MULT/MULTU/DIV/DIVU arriving while busy SHALL be ignored. This is unreachable under REQ-021 and is asserted in verification.
REQ-028 E_valid=0 SHALL suppress start and all HI/LO writes.

Reset
REQ-029 reset low SHALL asynchronously force state=IDLE, cnt=0, HI=0, LO=0, latched operands=0; busy=0 immediately.
REQ-030 Reset mid-operation SHALL abandon the result; no HI/LO write after release.
REQ-031 The first start SHALL be accepted in the first cycle after reset deasserts.

Structure
REQ-032 MDU op encodings, FSM state codes and default cycle counts SHALL live in the shared constants header used by the control decoder.
REQ-033 Arithmetic SHALL sit in one combinational sub-module mdu_calc (inputs: operands, op; outputs: hi, lo, div0). mdu_ctrl owns the FSM, counter, registers and stall.

Verification
REQ-034 MULT A=5, B=0xFFFFFFFD -> start 1 cycle, busy 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
REQ-035 DIVU 7/2 -> busy 10 cycles, then LO=3, HI=1. DIV 0xFFFFFFF9/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-036 MTHI 0x1234 (idle), DIV x/0 -> after 10 busy cycles HI=0x1234 and LO unchanged.
REQ-037 MULT followed by MFLO in D -> stall high in the start cycle plus 5 busy cycles; MFLO in E then reads the new LO.
REQ-038 reset pulsed low at busy cycle 4 of DIV -> busy=0 immediately; HI=LO=0 after release; no late write.
REQ-039 MTHI in E while busy (forced, stall ignored) -> HI unchanged; the assertion in REQ-027 fires only for MULT/DIV overlap.
